// File: rtl/eco32_core_lsu_dcm_mrt.sv
// rtl/eco32_core_lsu_dcm_mrt.sv - miss request tracker for the LSU data cache miss path
module eco32_core_lsu_dcm_mrt #(
    parameter int PAGE_ADDR_WIDTH = 5,
    parameter int SLOTS           = 4,
    parameter int TID_WIDTH       = 1,
    parameter int LINE_LSB        = 6,
    parameter int TIMEOUT         = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rdy,
    input  logic                       req_stb,
    input  logic [TID_WIDTH-1:0]       req_tid,
    input  logic                       req_wid,
    input  logic [PAGE_ADDR_WIDTH-1:0] req_page,
    input  logic [31:0]                req_v_addr,
    output logic                       req_rdy,
    output logic                       tx_stb,
    output logic [3:0]                 tx_rid,
    output logic [TID_WIDTH-1:0]       tx_tid,
    output logic [31:0]                tx_v_addr,
    input  logic                       tx_ack,
    input  logic                       ack_stb,
    input  logic [3:0]                 ack_rid,
    input  logic [31:0]                ack_ph_addr,
    output logic                       done_stb,
    output logic                       done_err,
    output logic [3:0]                 done_rid,
    output logic [TID_WIDTH-1:0]       done_tid,
    output logic                       done_wid,
    output logic [PAGE_ADDR_WIDTH-1:0] done_page,
    output logic [31:0]                done_ph_addr,
    output logic                       err_spurious,
    output logic [4:0]                 occupancy
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_WAIT = 2'd2
    } slot_state_t;

    slot_state_t                state_q [SLOTS];
    slot_state_t                state_d [SLOTS];
    logic [TMR_W-1:0]           timer_q [SLOTS];
    logic [TMR_W-1:0]           timer_d [SLOTS];
    logic [TID_WIDTH-1:0]       tid_q   [SLOTS];
    logic                       wid_q   [SLOTS];
    logic [PAGE_ADDR_WIDTH-1:0] page_q  [SLOTS];
    logic [31:0]                vaddr_q [SLOTS];

    logic [1:0]                 init_cnt;

    logic                       any_free;
    logic [3:0]                 alloc_idx;
    logic                       line_hit;
    logic                       alloc;
    logic                       any_pend;
    logic [3:0]                 pend_idx;
    logic [TID_WIDTH-1:0]       pend_tid;
    logic [31:0]                pend_v_addr;
    logic                       ack_valid;
    logic                       to_valid;
    logic [3:0]                 to_idx;
    logic                       retire;
    logic [3:0]                 ret_idx;
    logic [TID_WIDTH-1:0]       ret_tid;
    logic                       ret_wid;
    logic [PAGE_ADDR_WIDTH-1:0] ret_page;

    // Counts four cycles out of reset before the tracker accepts work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= 2'd0;
            rdy      <= 1'b0;
        end else if (!rdy) begin
            init_cnt <= init_cnt + 2'd1;
            if (init_cnt == 2'd3) rdy <= 1'b1;
        end
    end

    // Selection logic works purely off registered slot state, so a slot
    // freed at an edge only becomes allocatable in the following cycle.
    always_comb begin
        any_free    = 1'b0;
        alloc_idx   = 4'd0;
        line_hit    = 1'b0;
        any_pend    = 1'b0;
        pend_idx    = 4'd0;
        pend_tid    = '0;
        pend_v_addr = 32'd0;
        ack_valid   = 1'b0;
        to_valid    = 1'b0;
        to_idx      = 4'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == SLOT_FREE) begin
                any_free  = 1'b1;
                alloc_idx = 4'(i);
            end
            if (state_q[i] == SLOT_PEND) begin
                any_pend    = 1'b1;
                pend_idx    = 4'(i);
                pend_tid    = tid_q[i];
                pend_v_addr = vaddr_q[i];
            end
            if (TMO_EN && state_q[i] == SLOT_WAIT && timer_q[i] == TMR_MAX) begin
                to_valid = 1'b1;
                to_idx   = 4'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (state_q[i] != SLOT_FREE && tid_q[i] == req_tid &&
                vaddr_q[i][31:LINE_LSB] == req_v_addr[31:LINE_LSB]) begin
                line_hit = 1'b1;
            end
            if (ack_stb && ack_rid == 4'(i) && state_q[i] == SLOT_WAIT) begin
                ack_valid = 1'b1;
            end
        end
    end

    assign req_rdy = rdy & any_free & ~line_hit;
    assign alloc   = req_stb & req_rdy;
    assign retire  = ack_valid | to_valid;
    assign ret_idx = ack_valid ? ack_rid : to_idx;

    always_comb begin
        ret_tid  = '0;
        ret_wid  = 1'b0;
        ret_page = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (retire && ret_idx == 4'(i)) begin
                ret_tid  = tid_q[i];
                ret_wid  = wid_q[i];
                ret_page = page_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                SLOT_FREE: begin
                    if (alloc && alloc_idx == 4'(i)) state_d[i] = SLOT_PEND;
                end
                SLOT_PEND: begin
                    if (tx_stb && tx_ack && tx_rid == 4'(i)) begin
                        state_d[i] = SLOT_WAIT;
                        timer_d[i] = '0;
                    end
                end
                SLOT_WAIT: begin
                    if (retire && ret_idx == 4'(i)) begin
                        state_d[i] = SLOT_FREE;
                    end else if (timer_q[i] != TMR_MAX) begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= SLOT_FREE;
                timer_q[i] <= '0;
                tid_q[i]   <= '0;
                wid_q[i]   <= 1'b0;
                page_q[i]  <= '0;
                vaddr_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                if (alloc && alloc_idx == 4'(i)) begin
                    tid_q[i]   <= req_tid;
                    wid_q[i]   <= req_wid;
                    page_q[i]  <= req_page;
                    vaddr_q[i] <= req_v_addr;
                end
            end
        end
    end

    // The presented request is held until consumed; the next pending slot
    // is looked up one cycle after the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_stb    <= 1'b0;
            tx_rid    <= 4'd0;
            tx_tid    <= '0;
            tx_v_addr <= 32'd0;
        end else if (tx_stb) begin
            if (tx_ack) tx_stb <= 1'b0;
        end else if (any_pend) begin
            tx_stb    <= 1'b1;
            tx_rid    <= pend_idx;
            tx_tid    <= pend_tid;
            tx_v_addr <= pend_v_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_stb     <= 1'b0;
            done_err     <= 1'b0;
            done_rid     <= 4'd0;
            done_tid     <= '0;
            done_wid     <= 1'b0;
            done_page    <= '0;
            done_ph_addr <= 32'd0;
            err_spurious <= 1'b0;
            occupancy    <= 5'd0;
        end else begin
            done_stb     <= retire;
            done_err     <= retire & ~ack_valid;
            done_rid     <= retire ? ret_idx : 4'd0;
            done_tid     <= ret_tid;
            done_wid     <= ret_wid;
            done_page    <= ret_page;
            done_ph_addr <= ack_valid ? ack_ph_addr : 32'd0;
            err_spurious <= err_spurious | (ack_stb & ~ack_valid);
            occupancy    <= occupancy + {4'd0, alloc} - {4'd0, retire};
        end
    end

endmodule

// File: tb/tb_eco32_core_lsu_dcm_mrt.sv
// tb/tb_eco32_core_lsu_dcm_mrt.sv - randomized bench with slot-level reference model
module tb_eco32_core_lsu_dcm_mrt;

    localparam int NS  = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        req_stb;
    logic [0:0]  req_tid;
    logic        req_wid;
    logic [4:0]  req_page;
    logic [31:0] req_v_addr;
    logic        req_rdy;
    logic        tx_stb;
    logic [3:0]  tx_rid;
    logic [0:0]  tx_tid;
    logic [31:0] tx_v_addr;
    logic        tx_ack;
    logic        ack_stb;
    logic [3:0]  ack_rid;
    logic [31:0] ack_ph_addr;
    logic        done_stb;
    logic        done_err;
    logic [3:0]  done_rid;
    logic [0:0]  done_tid;
    logic        done_wid;
    logic [4:0]  done_page;
    logic [31:0] done_ph_addr;
    logic        err_spurious;
    logic [4:0]  occupancy;

    eco32_core_lsu_dcm_mrt #(
        .PAGE_ADDR_WIDTH(5), .SLOTS(NS), .TID_WIDTH(1), .LINE_LSB(6), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_stb(req_stb), .req_tid(req_tid), .req_wid(req_wid), .req_page(req_page),
        .req_v_addr(req_v_addr), .req_rdy(req_rdy),
        .tx_stb(tx_stb), .tx_rid(tx_rid), .tx_tid(tx_tid), .tx_v_addr(tx_v_addr), .tx_ack(tx_ack),
        .ack_stb(ack_stb), .ack_rid(ack_rid), .ack_ph_addr(ack_ph_addr),
        .done_stb(done_stb), .done_err(done_err), .done_rid(done_rid), .done_tid(done_tid),
        .done_wid(done_wid), .done_page(done_page), .done_ph_addr(done_ph_addr),
        .err_spurious(err_spurious), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Reference model: which slots hold a miss, which have been sent,
    // and how many cycles each sent miss has waited.
    bit          m_busy [NS];
    bit          m_sent [NS];
    int          m_age  [NS];
    logic [0:0]  m_tid  [NS];
    logic        m_wid  [NS];
    logic [4:0]  m_page [NS];
    logic [31:0] m_addr [NS];
    int          m_edges;
    bit          m_spur;
    bit          m_tx_stb;
    int          m_tx_rid;
    bit          m_done;
    bit          m_d_err;
    int          m_d_rid;
    logic [0:0]  m_d_tid;
    logic        m_d_wid;
    logic [4:0]  m_d_page;
    logic [31:0] m_d_ph;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        for (int s = 0; s < NS; s++) begin
            m_busy[s] = 0; m_sent[s] = 0; m_age[s] = 0;
            m_tid[s] = 0; m_wid[s] = 0; m_page[s] = 0; m_addr[s] = 0;
        end
        m_edges = 0; m_spur = 0; m_tx_stb = 0; m_tx_rid = 0; m_done = 0;
    endtask

    function automatic int m_occ();
        int c = 0;
        for (int s = 0; s < NS; s++) if (m_busy[s]) c++;
        return c;
    endfunction

    task automatic drive_idle();
        req_stb = 0; req_tid = 0; req_wid = 0; req_page = 0; req_v_addr = 0;
        tx_ack = 0; ack_stb = 0; ack_rid = 0; ack_ph_addr = 0;
    endtask

    // One clock: drive inputs, predict, advance, compare.
    task automatic cycle(input bit rs, input bit tid, input bit wid, input logic [4:0] pg,
                         input logic [31:0] va, input bit ta, input bit as,
                         input logic [3:0] ar, input logic [31:0] ph);
        bit exp_rr, hit, acc, ack_ok;
        int free_i, to_i, ret_i, pend_i, sent_i;
        req_stb = rs; req_tid = tid; req_wid = wid; req_page = pg; req_v_addr = va;
        tx_ack = ta; ack_stb = as; ack_rid = ar; ack_ph_addr = ph;
        #1;
        free_i = -1; hit = 0; to_i = -1; pend_i = -1;
        for (int s = 0; s < NS; s++) begin
            if (!m_busy[s] && free_i < 0) free_i = s;
            if (m_busy[s] && m_tid[s] == tid && m_addr[s][31:6] == va[31:6]) hit = 1;
            if (to_i < 0 && m_busy[s] && m_sent[s] && m_age[s] == TMO) to_i = s;
            if (pend_i < 0 && m_busy[s] && !m_sent[s]) pend_i = s;
        end
        exp_rr = (m_edges >= 4) && (free_i >= 0) && !hit;
        chk("req_rdy", req_rdy, exp_rr);
        acc = rs && exp_rr;
        ack_ok = 0;
        if (as && ar < NS) ack_ok = m_busy[ar] && m_sent[ar];
        if (as && !ack_ok) m_spur = 1;
        m_done = ack_ok || (to_i >= 0);
        ret_i = ack_ok ? int'(ar) : to_i;
        if (m_done) begin
            m_d_err = !ack_ok; m_d_rid = ret_i; m_d_tid = m_tid[ret_i];
            m_d_wid = m_wid[ret_i]; m_d_page = m_page[ret_i];
            m_d_ph = ack_ok ? ph : 32'd0;
        end
        sent_i = (m_tx_stb && ta) ? m_tx_rid : -1;
        if (m_tx_stb) begin
            if (ta) m_tx_stb = 0;
        end else if (pend_i >= 0) begin
            m_tx_stb = 1; m_tx_rid = pend_i;
        end
        for (int s = 0; s < NS; s++) if (m_sent[s] && m_age[s] < TMO) m_age[s]++;
        if (sent_i >= 0) begin m_sent[sent_i] = 1; m_age[sent_i] = 0; end
        if (m_done) begin m_busy[ret_i] = 0; m_sent[ret_i] = 0; end
        if (acc) begin
            m_busy[free_i] = 1; m_sent[free_i] = 0;
            m_tid[free_i] = tid; m_wid[free_i] = wid; m_page[free_i] = pg; m_addr[free_i] = va;
        end
        m_edges++;
        @(posedge clk);
        @(negedge clk);
        chk("rdy", rdy, m_edges >= 4);
        chk("done_stb", done_stb, m_done);
        if (m_done) begin
            chk("done_err", done_err, m_d_err);
            chk("done_rid", done_rid, m_d_rid);
            chk("done_tid", done_tid, m_d_tid);
            chk("done_wid", done_wid, m_d_wid);
            chk("done_page", done_page, m_d_page);
            chk("done_ph_addr", done_ph_addr, m_d_ph);
        end
        chk("tx_stb", tx_stb, m_tx_stb);
        if (m_tx_stb) begin
            chk("tx_rid", tx_rid, m_tx_rid);
            chk("tx_tid", tx_tid, m_tid[m_tx_rid]);
            chk("tx_v_addr", tx_v_addr, m_addr[m_tx_rid]);
        end
        chk("occupancy", occupancy, m_occ());
        chk("err_spurious", err_spurious, m_spur);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic req(input bit tid, input logic [31:0] va, input logic [4:0] pg);
        cycle(1, tid, va[12], pg, va, 0, 0, 0, 0);
    endtask

    task automatic ack(input logic [3:0] rid, input logic [31:0] ph);
        cycle(0, 0, 0, 0, 0, 0, 1, rid, ph);
    endtask

    task automatic send_all(input int bound);
        int k = 0;
        bit pend = 1;
        while (pend && k < bound) begin
            cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
            k++;
            pend = 0;
            for (int s = 0; s < NS; s++) if (m_busy[s] && !m_sent[s]) pend = 1;
        end
        chk("send_all_bound", pend, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1;
        m_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rs, tid, ta, as;
        logic [3:0]  ar;
        logic [31:0] va;
        int          wq[$];
        int          k;
        n_checks = 0; n_pass = 0;
        rst = 0;
        drive_idle();
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_tx_stb", tx_stb, 0);
        chk("rst_done_stb", done_stb, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_err_spurious", err_spurious, 0);
        rst = 1;

        // Basic miss: blocked until ready, then same-line blocking per thread.
        repeat (6) cycle(1, 0, 0, 5'd3, 32'h0000_1040, 0, 0, 0, 0);
        req(1, 32'h0000_1040, 5'd4);
        req(0, 32'h0000_1078, 5'd5);
        send_all(10);
        ack(0, 32'h8000_1040);
        chk("t1_done_ph", done_ph_addr, 32'h8000_1040);
        chk("t1_done_rid", done_rid, 0);
        ack(1, 32'h8000_2040);
        idle(1);
        chk("t1_occ_empty", occupancy, 0);

        // Fill all slots, free slot 2, refill it, then let the rest time out.
        req(0, 32'h0000_2000, 5'd1);
        req(0, 32'h0000_3000, 5'd2);
        req(1, 32'h0000_4000, 5'd3);
        req(0, 32'h0000_5000, 5'd4);
        req(0, 32'h0000_6000, 5'd5);
        chk("fill_occ", occupancy, 4);
        send_all(12);
        ack(2, 32'h9000_0000);
        req(0, 32'h0000_6000, 5'd6);
        send_all(4);
        idle(20);
        chk("timeout_drain_occ", occupancy, 0);

        // Ack and timeout in the same cycle; then an ack to a free slot.
        do_reset();
        idle(4);
        req(0, 32'h0000_7000, 5'd7);
        req(0, 32'h0000_8000, 5'd8);
        send_all(8);
        k = 0;
        while (m_age[0] != TMO && k < 20) begin idle(1); k++; end
        chk("collide_setup", m_age[0] == TMO && m_busy[1] && m_sent[1], 1);
        ack(1, 32'hA000_0000);
        chk("collide_first_rid", done_rid, 1);
        chk("collide_first_err", done_err, 0);
        idle(1);
        chk("collide_second_rid", done_rid, 0);
        chk("collide_second_err", done_err, 1);
        ack(3, 32'hB000_0000);
        chk("spurious_flag", err_spurious, 1);
        chk("spurious_no_done", done_stb, 0);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rs  = ($urandom_range(0, 99) < 45);
            tid = 1'($urandom_range(0, 1));
            va  = 32'h0000_1000 + (32'($urandom_range(0, 5)) << 6) + 32'($urandom_range(0, 63));
            ta  = ($urandom_range(0, 99) < 60);
            as  = ($urandom_range(0, 99) < 25);
            wq.delete();
            for (int s = 0; s < NS; s++) if (m_busy[s] && m_sent[s]) wq.push_back(s);
            if (wq.size() > 0 && $urandom_range(0, 9) < 8)
                ar = 4'(wq[$urandom_range(0, wq.size() - 1)]);
            else
                ar = 4'($urandom_range(0, 15));
            cycle(rs, tid, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), va, ta, as, ar, $urandom());
        end

        // Asynchronous reset with three misses waiting.
        do_reset();
        idle(4);
        req(0, 32'h0000_1000, 5'd1);
        req(0, 32'h0000_2000, 5'd2);
        req(0, 32'h0000_3000, 5'd3);
        send_all(10);
        #2 rst = 0;
        #1;
        chk("arst_rdy", rdy, 0);
        chk("arst_tx_stb", tx_stb, 0);
        chk("arst_done_stb", done_stb, 0);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_err_spurious", err_spurious, 0);
        chk("arst_req_rdy", req_rdy, 0);
        @(negedge clk);
        rst = 1;
        m_reset();
        idle(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
